// File: rtl/sram_dp_be.sv
// sram_dp_be: true dual-port word RAM with byte enables, READ_LAT 1/2 read pipeline and
// a cross-port collision flag. Define SRAM_DP_BE_PARITY_EN for per-lane even parity.
module sram_dp_be #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_rvalid,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_rvalid,
  output logic                    coll,
  output logic                    a_perr,
  output logic                    b_perr
);
  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  a_wr, b_wr, same_addr, coll_c;
  logic [DATA_WIDTH-1:0] a_ret, b_ret;
  logic [NB-1:0]         a_mis, b_mis;

  // Returned word: own write lands on top (write-first); the other port's same-address
  // write is only merged in for writers, so a cross-port reader sees the old word.
  always_comb begin
    a_wr      = a_req & a_we;
    b_wr      = b_req & b_we;
    same_addr = (a_addr == b_addr);
    coll_c    = a_req & b_req & same_addr & (a_we | b_we);
    a_ret     = mem_q[a_addr];
    b_ret     = mem_q[b_addr];
    for (int i = 0; i < int'(NB); i++) begin
      if (a_wr && b_wr && same_addr && b_be[i]) a_ret[8*i +: 8] = b_wdata[8*i +: 8];
      if (a_wr && a_be[i])                      a_ret[8*i +: 8] = a_wdata[8*i +: 8];
      if (b_wr && b_be[i])                      b_ret[8*i +: 8] = b_wdata[8*i +: 8];
      if (b_wr && a_wr && same_addr && a_be[i]) b_ret[8*i +: 8] = a_wdata[8*i +: 8];
    end
  end

  // Array write; port A is applied last so it wins overlapping lanes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (b_wr && b_be[i]) mem_q[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        if (a_wr && a_be[i]) mem_q[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

`ifdef SRAM_DP_BE_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] a_pret, b_pret, a_wpar, b_wpar;

  always_comb begin
    a_pret = par_q[a_addr];
    b_pret = par_q[b_addr];
    for (int i = 0; i < int'(NB); i++) begin
      a_wpar[i] = ^a_wdata[8*i +: 8];
      b_wpar[i] = ^b_wdata[8*i +: 8];
      if (a_wr && b_wr && same_addr && b_be[i]) a_pret[i] = b_wpar[i];
      if (a_wr && a_be[i])                      a_pret[i] = a_wpar[i];
      if (b_wr && b_be[i])                      b_pret[i] = b_wpar[i];
      if (b_wr && a_wr && same_addr && a_be[i]) b_pret[i] = a_wpar[i];
      a_mis[i] = (^a_ret[8*i +: 8]) ^ a_pret[i];
      b_mis[i] = (^b_ret[8*i +: 8]) ^ b_pret[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (b_wr && b_be[i]) par_q[b_addr][i] <= b_wpar[i];
        if (a_wr && a_be[i]) par_q[a_addr][i] <= a_wpar[i];
      end
    end
  end
`else
  assign a_mis = '0;
  assign b_mis = '0;
`endif

  logic                  a_v1_q, a_v1_d, b_v1_q, b_v1_d, c1_q, c1_d;
  logic                  a_p1_q, a_p1_d, b_p1_q, b_p1_d;
  logic [DATA_WIDTH-1:0] a_d1_q, a_d1_d, b_d1_q, b_d1_d;

  always_comb begin
    a_v1_d = a_req;
    b_v1_d = b_req;
    c1_d   = coll_c;
    a_p1_d = a_req & (|a_mis);
    b_p1_d = b_req & (|b_mis);
    a_d1_d = a_req ? a_ret : a_d1_q;
    b_d1_d = b_req ? b_ret : b_d1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_v1_q <= 1'b0;
      b_v1_q <= 1'b0;
      c1_q   <= 1'b0;
      a_p1_q <= 1'b0;
      b_p1_q <= 1'b0;
      a_d1_q <= '0;
      b_d1_q <= '0;
    end else begin
      a_v1_q <= a_v1_d;
      b_v1_q <= b_v1_d;
      c1_q   <= c1_d;
      a_p1_q <= a_p1_d;
      b_p1_q <= b_p1_d;
      a_d1_q <= a_d1_d;
      b_d1_q <= b_d1_d;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic                  a_v2_q, a_v2_d, b_v2_q, b_v2_d, c2_q, c2_d;
    logic                  a_p2_q, a_p2_d, b_p2_q, b_p2_d;
    logic [DATA_WIDTH-1:0] a_d2_q, a_d2_d, b_d2_q, b_d2_d;

    always_comb begin
      a_v2_d = a_v1_q;
      b_v2_d = b_v1_q;
      c2_d   = c1_q;
      a_p2_d = a_p1_q;
      b_p2_d = b_p1_q;
      a_d2_d = a_v1_q ? a_d1_q : a_d2_q;
      b_d2_d = b_v1_q ? b_d1_q : b_d2_q;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_v2_q <= 1'b0;
        b_v2_q <= 1'b0;
        c2_q   <= 1'b0;
        a_p2_q <= 1'b0;
        b_p2_q <= 1'b0;
        a_d2_q <= '0;
        b_d2_q <= '0;
      end else begin
        a_v2_q <= a_v2_d;
        b_v2_q <= b_v2_d;
        c2_q   <= c2_d;
        a_p2_q <= a_p2_d;
        b_p2_q <= b_p2_d;
        a_d2_q <= a_d2_d;
        b_d2_q <= b_d2_d;
      end
    end

    assign a_rvalid = a_v2_q;
    assign b_rvalid = b_v2_q;
    assign a_rdata  = a_d2_q;
    assign b_rdata  = b_d2_q;
    assign coll     = c2_q;
    assign a_perr   = a_p2_q;
    assign b_perr   = b_p2_q;
  end else begin : g_lat1
    assign a_rvalid = a_v1_q;
    assign b_rvalid = b_v1_q;
    assign a_rdata  = a_d1_q;
    assign b_rdata  = b_d1_q;
    assign coll     = c1_q;
    assign a_perr   = a_p1_q;
    assign b_perr   = b_p1_q;
  end

endmodule

// File: tb/tb_sram_dp_be.sv
// tb_sram_dp_be: drives one READ_LAT=1 and one READ_LAT=2 instance with identical stimulus
// and scores both against a behavioural memory model.
module tb_sram_dp_be;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  typedef struct packed {
    logic          av;
    logic [DW-1:0] ad;
    logic          bv;
    logic [DW-1:0] bd;
    logic          c;
    logic          ap;
    logic          bp;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [3:0]    a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [DW-1:0] l1_a_rdata, l1_b_rdata, l2_a_rdata, l2_b_rdata;
  logic          l1_a_rvalid, l1_b_rvalid, l1_coll, l1_a_perr, l1_b_perr;
  logic          l2_a_rvalid, l2_b_rvalid, l2_coll, l2_a_perr, l2_b_perr;

  always #5 clk = ~clk;

  sram_dp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(l1_a_rdata), .a_rvalid(l1_a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(l1_b_rdata), .b_rvalid(l1_b_rvalid),
    .coll(l1_coll), .a_perr(l1_a_perr), .b_perr(l1_b_perr)
  );

  sram_dp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(2)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(l2_a_rdata), .a_rvalid(l2_a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(l2_b_rdata), .b_rvalid(l2_b_rvalid),
    .coll(l2_coll), .a_perr(l2_a_perr), .b_perr(l2_b_perr)
  );

  logic [DW-1:0] mdl [int];
  bit            corrupt [int];
  obs_t          q1 [$];
  obs_t          q2 [$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;

  function automatic op_t rd(input logic [AW-1:0] addr);
    op_t o = '0;
    o.req  = 1'b1;
    o.addr = addr;
    return o;
  endfunction

  function automatic op_t wr(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] be);
    op_t o = '0;
    o.req   = 1'b1;
    o.we    = 1'b1;
    o.be    = be;
    o.addr  = addr;
    o.wdata = data;
    return o;
  endfunction

  function automatic op_t idle();
    op_t o = '0;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.req   = ($urandom_range(3) != 0);
    o.we    = ($urandom_range(1) == 1);
    o.be    = 4'($urandom_range(15));
    o.addr  = AW'(32'h100 + $urandom_range(7));
    o.wdata = $urandom;
    return o;
  endfunction

  function automatic logic [DW-1:0] peek(input logic [AW-1:0] addr);
    if (mdl.exists(int'(addr))) return mdl[int'(addr)];
    return 'x;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input op_t o);
    logic [DW-1:0] r = old;
    for (int i = 0; i < 4; i++) if (o.be[i]) r[8*i +: 8] = o.wdata[8*i +: 8];
    return r;
  endfunction

  function automatic obs_t sample(input int lat);
    obs_t o;
    if (lat == 1) begin
      o.av = l1_a_rvalid; o.ad = l1_a_rvalid ? l1_a_rdata : '0;
      o.bv = l1_b_rvalid; o.bd = l1_b_rvalid ? l1_b_rdata : '0;
      o.c  = l1_coll;     o.ap = l1_a_perr;   o.bp = l1_b_perr;
    end else begin
      o.av = l2_a_rvalid; o.ad = l2_a_rvalid ? l2_a_rdata : '0;
      o.bv = l2_b_rvalid; o.bd = l2_b_rvalid ? l2_b_rdata : '0;
      o.c  = l2_coll;     o.ap = l2_a_perr;   o.bp = l2_b_perr;
    end
    return o;
  endfunction

  // Drive one cycle, push the model's expected response, then step past the edge.
  task automatic issue(input op_t a, input op_t b);
    obs_t          e = '0;
    logic [DW-1:0] aret, bret;
    logic          aw, bw, same;
    a_req = a.req; a_we = a.we; a_be = a.be; a_addr = a.addr; a_wdata = a.wdata;
    b_req = b.req; b_we = b.we; b_be = b.be; b_addr = b.addr; b_wdata = b.wdata;
    if (!rst_n) begin
      q1.delete();
      q2.delete();
      q1.push_back(e);
      q2.push_back(e);
      q2.push_back(e);
    end else begin
      aw   = a.req && a.we;
      bw   = b.req && b.we;
      same = (a.addr == b.addr);
      aret = peek(a.addr);
      bret = peek(b.addr);
      if (aw) begin
        if (bw && same) aret = merge(aret, b);
        aret = merge(aret, a);
      end
      if (bw) begin
        bret = merge(bret, b);
        if (aw && same) bret = merge(bret, a);
      end
      if (bw) mdl[int'(b.addr)] = merge(peek(b.addr), b);
      if (aw) mdl[int'(a.addr)] = merge(peek(a.addr), a);
      e.av = a.req;
      e.ad = a.req ? aret : '0;
      e.bv = b.req;
      e.bd = b.req ? bret : '0;
      e.c  = a.req && b.req && same && (a.we || b.we);
      e.ap = a.req && !a.we && corrupt.exists(int'(a.addr));
      e.bp = b.req && !b.we && corrupt.exists(int'(b.addr));
      q1.push_back(e);
      q2.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    obs_t g, e;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      issue(wr(10'h3FF, 32'hFFFF_FFFF, 4'hF), rd(10'h3FF));
      for (int lat = 1; lat <= 2; lat++) begin
        g = sample(lat);
        e = (lat == 1) ? q1.pop_front() : q2.pop_front();
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL reset lat%0d cyc%0d: got %h required %h", lat, cyc, g, e);
        end
      end
      n_cmp++;
      if ({l1_a_rdata, l1_b_rdata, l2_a_rdata, l2_b_rdata} !== 128'h0) begin
        n_err++;
        $display("FAIL reset_rdata cyc%0d: got %h %h %h %h required 0", cyc,
                 l1_a_rdata, l1_b_rdata, l2_a_rdata, l2_b_rdata);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_roundtrip();
    op_t  oa [$];
    obs_t g, e;
    oa.push_back(wr(10'h010, 32'hDEAD_BEEF, 4'hF));
    oa.push_back(rd(10'h010));
    oa.push_back(idle());
    oa.push_back(idle());
    foreach (oa[k]) begin
      issue(oa[k], idle());
      for (int lat = 1; lat <= 2; lat++) begin
        g = sample(lat);
        e = (lat == 1) ? q1.pop_front() : q2.pop_front();
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL roundtrip lat%0d step%0d: got %h required %h", lat, k, g, e);
        end
      end
      if (k == 1) begin
        n_cmp++;
        if (l1_a_rvalid !== 1'b1 || l1_a_rdata !== 32'hDEAD_BEEF || l1_coll !== 1'b0) begin
          n_err++;
          $display("FAIL roundtrip_l1: got v=%b d=%h c=%b required v=1 d=deadbeef c=0",
                   l1_a_rvalid, l1_a_rdata, l1_coll);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if (l1_a_rvalid !== 1'b0 || l1_a_rdata !== 32'hDEAD_BEEF ||
            l2_a_rvalid !== 1'b1 || l2_a_rdata !== 32'hDEAD_BEEF) begin
          n_err++;
          $display("FAIL hold_l1_valid_l2: got l1 v=%b d=%h l2 v=%b d=%h", l1_a_rvalid,
                   l1_a_rdata, l2_a_rvalid, l2_a_rdata);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (l2_a_rvalid !== 1'b0 || l2_a_rdata !== 32'hDEAD_BEEF) begin
          n_err++;
          $display("FAIL hold_l2: got v=%b d=%h required v=0 d=deadbeef", l2_a_rvalid,
                   l2_a_rdata);
        end
      end
    end
  endtask

  task automatic test_byte_enables();
    op_t  oa [$];
    obs_t g, e;
    oa.push_back(wr(10'h020, 32'h1122_3344, 4'hF));
    oa.push_back(wr(10'h020, 32'hAABB_CCDD, 4'b0101));
    oa.push_back(rd(10'h020));
    oa.push_back(wr(10'h020, 32'hFFFF_FFFF, 4'h0));
    oa.push_back(rd(10'h020));
    oa.push_back(idle());
    foreach (oa[k]) begin
      issue(oa[k], idle());
      for (int lat = 1; lat <= 2; lat++) begin
        g = sample(lat);
        e = (lat == 1) ? q1.pop_front() : q2.pop_front();
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL byte_en lat%0d step%0d: got %h required %h", lat, k, g, e);
        end
      end
      if (k == 2 || k == 4) begin
        n_cmp++;
        if (l1_a_rvalid !== 1'b1 || l1_a_rdata !== 32'h11BB_33DD) begin
          n_err++;
          $display("FAIL byte_en_value step%0d: got v=%b d=%h required v=1 d=11bb33dd", k,
                   l1_a_rvalid, l1_a_rdata);
        end
      end
    end
  endtask

  task automatic test_dual_write();
    op_t  oa [$];
    op_t  ob [$];
    obs_t g, e;
    oa.push_back(wr(10'h030, 32'h0, 4'hF));          ob.push_back(idle());
    oa.push_back(wr(10'h030, 32'hAAAA_AAAA, 4'b0011)); ob.push_back(wr(10'h030, 32'hBBBB_BBBB, 4'b0110));
    oa.push_back(rd(10'h030));                       ob.push_back(idle());
    oa.push_back(idle());                            ob.push_back(idle());
    foreach (oa[k]) begin
      issue(oa[k], ob[k]);
      for (int lat = 1; lat <= 2; lat++) begin
        g = sample(lat);
        e = (lat == 1) ? q1.pop_front() : q2.pop_front();
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL dual_write lat%0d step%0d: got %h required %h", lat, k, g, e);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if (l1_a_rdata !== 32'h00BB_AAAA || l1_coll !== 1'b0 || l2_coll !== 1'b1) begin
          n_err++;
          $display("FAIL dual_write_value: got d=%h l1c=%b l2c=%b required 00bbaaaa 0 1",
                   l1_a_rdata, l1_coll, l2_coll);
        end
      end
    end
  endtask

  task automatic test_cross_rw();
    op_t  oa [$];
    op_t  ob [$];
    obs_t g, e;
    oa.push_back(wr(10'h040, 32'h1, 4'hF)); ob.push_back(idle());
    oa.push_back(wr(10'h040, 32'h2, 4'hF)); ob.push_back(rd(10'h040));
    oa.push_back(rd(10'h040));              ob.push_back(rd(10'h040));
    oa.push_back(rd(10'h040));              ob.push_back(wr(10'h040, 32'h3, 4'hF));
    oa.push_back(rd(10'h040));              ob.push_back(idle());
    oa.push_back(idle());                   ob.push_back(idle());
    foreach (oa[k]) begin
      issue(oa[k], ob[k]);
      for (int lat = 1; lat <= 2; lat++) begin
        g = sample(lat);
        e = (lat == 1) ? q1.pop_front() : q2.pop_front();
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL cross_rw lat%0d step%0d: got %h required %h", lat, k, g, e);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if (l2_a_rvalid !== 1'b1 || l2_a_rdata !== 32'h2 || l2_b_rvalid !== 1'b1 ||
            l2_b_rdata !== 32'h1 || l2_coll !== 1'b1) begin
          n_err++;
          $display("FAIL cross_rw_l2: got a=%h b=%h c=%b required a=2 b=1 c=1",
                   l2_a_rdata, l2_b_rdata, l2_coll);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (l2_coll !== 1'b0 || l2_a_rdata !== 32'h2 || l2_b_rdata !== 32'h2) begin
          n_err++;
          $display("FAIL same_read_l2: got a=%h b=%h c=%b required a=2 b=2 c=0",
                   l2_a_rdata, l2_b_rdata, l2_coll);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t g, e;
    op_t  a, b;
    for (int k = 0; k < 50; k++) begin
      if (k < 8) begin
        a = wr(AW'(32'h100 + k), $urandom, 4'hF);
        b = idle();
      end else if (k >= 48) begin
        a = idle();
        b = idle();
      end else begin
        a = rnd_op();
        b = rnd_op();
      end
      issue(a, b);
      for (int lat = 1; lat <= 2; lat++) begin
        g = sample(lat);
        e = (lat == 1) ? q1.pop_front() : q2.pop_front();
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL back_to_back lat%0d step%0d: got %h required %h", lat, k, g, e);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    op_t  oa [$];
    bit   rs [$];
    obs_t g, e;
    oa.push_back(rd(10'h010));                 rs.push_back(1'b1);
    oa.push_back(wr(10'h010, 32'h0, 4'hF));    rs.push_back(1'b0);
    oa.push_back(idle());                      rs.push_back(1'b0);
    oa.push_back(rd(10'h010));                 rs.push_back(1'b1);
    oa.push_back(idle());                      rs.push_back(1'b1);
    foreach (oa[k]) begin
      rst_n = rs[k];
      issue(oa[k], idle());
      for (int lat = 1; lat <= 2; lat++) begin
        g = sample(lat);
        e = (lat == 1) ? q1.pop_front() : q2.pop_front();
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL reset_mid lat%0d step%0d: got %h required %h", lat, k, g, e);
        end
      end
      if (k == 1 || k == 2) begin
        n_cmp++;
        if ({l1_a_rvalid, l2_a_rvalid, l1_coll, l2_coll, l1_a_rdata, l2_a_rdata} !== 68'h0) begin
          n_err++;
          $display("FAIL reset_mid_zero step%0d: got l1v=%b l2v=%b l1d=%h l2d=%h", k,
                   l1_a_rvalid, l2_a_rvalid, l1_a_rdata, l2_a_rdata);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (l2_a_rvalid !== 1'b1 || l2_a_rdata !== 32'hDEAD_BEEF) begin
          n_err++;
          $display("FAIL reset_mid_persist: got v=%b d=%h required v=1 d=deadbeef",
                   l2_a_rvalid, l2_a_rdata);
        end
      end
    end
  endtask

`ifdef SRAM_DP_BE_PARITY_EN
  task automatic test_parity();
    op_t  oa [$];
    op_t  ob [$];
    obs_t g, e;
    oa.push_back(wr(10'h060, 32'h1234_5678, 4'hF)); ob.push_back(idle());
    oa.push_back(rd(10'h060));                      ob.push_back(rd(10'h010));
    oa.push_back(idle());                           ob.push_back(idle());
    foreach (oa[k]) begin
      issue(oa[k], ob[k]);
      for (int lat = 1; lat <= 2; lat++) begin
        g = sample(lat);
        e = (lat == 1) ? q1.pop_front() : q2.pop_front();
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL parity lat%0d step%0d: got %h required %h", lat, k, g, e);
        end
      end
      if (k == 0) begin
        u_l1.mem_q[10'h060][0] = ~u_l1.mem_q[10'h060][0];
        u_l2.mem_q[10'h060][0] = ~u_l2.mem_q[10'h060][0];
        mdl[32'h60]     = mdl[32'h60] ^ 32'h1;
        corrupt[32'h60] = 1'b1;
      end
      if (k == 1) begin
        n_cmp++;
        if (l1_a_perr !== 1'b1 || l1_a_rvalid !== 1'b1 || l1_b_perr !== 1'b0) begin
          n_err++;
          $display("FAIL parity_flag: got a_perr=%b a_v=%b b_perr=%b required 1 1 0",
                   l1_a_perr, l1_a_rvalid, l1_b_perr);
        end
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_roundtrip();
    test_byte_enables();
    test_dual_write();
    test_cross_rw();
    test_back_to_back();
    test_reset_midflight();
`ifdef SRAM_DP_BE_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
